// File: rtl/div_pkg.sv
// Shared types and constants for the divider, aligner and multiplier blocks.
package div_pkg;

    localparam int unsigned DIV_W = 32;

    // Quotient reported on divide-by-zero.
    localparam logic [DIV_W-1:0] DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SUB   = 2'd2,
        FIX   = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_shiftsub_if.sv
// Start/done handshake, operands and HI/LO results of the divider.
interface div_shiftsub_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
);

    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] dvdnd;
    logic [WIDTH-1:0] dvsor;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Issue side: drives the request, observes the result.
    modport master (
        output start, sgn, dvdnd, dvsor,
        input  busy, done, dz, hi, lo
    );

    // Divider side.
    modport slave (
        input  start, sgn, dvdnd, dvsor,
        output busy, done, dz, hi, lo
    );

endinterface : div_shiftsub_if

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a value pair; used both for
// operand magnitude extraction and for result sign correction.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic             a_neg,
    input  logic [WIDTH-1:0] b,
    input  logic             b_neg,
    output logic [WIDTH-1:0] a_c,
    output logic [WIDTH-1:0] b_c
);

    // Negation wraps at WIDTH bits, so the most negative value maps to itself.
    assign a_c = a_neg ? -a : a;
    assign b_c = b_neg ? -b : b;

endmodule : div_sign_fix

// File: rtl/div_shiftsub.sv
// Multi-cycle restoring shift-subtract divider for DIV/DIVU.
// The divisor is first aligned under the dividend, then subtracted back down
// to bit 0; HI gets the remainder and LO the quotient.
module div_shiftsub
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           dvrst_n,
    div_shiftsub_if.slave  bus
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;            // running remainder magnitude
    logic [WIDTH:0]   d_q, d_d;            // shifted divisor, one spare bit
    logic [CNT_W-1:0] k_q, k_d;            // alignment shift count
    logic [WIDTH-1:0] q_q, q_d;            // quotient magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_pend_q, dz_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] dvdnd_mag_c;
    logic [WIDTH-1:0] dvsor_mag_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH:0]   d_shl_c;

    // Operand magnitudes (only signed ops take absolute values).
    div_sign_fix #(.WIDTH(WIDTH)) u_opnd_fix (
        .a     (bus.dvdnd),
        .a_neg (bus.sgn & bus.dvdnd[WIDTH-1]),
        .b     (bus.dvsor),
        .b_neg (bus.sgn & bus.dvsor[WIDTH-1]),
        .a_c   (dvdnd_mag_c),
        .b_c   (dvsor_mag_c)
    );

    // Signed results: quotient negative on sign mismatch, remainder follows dividend.
    div_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
        .a     (q_q),
        .a_neg (neg_quo_q),
        .b     (a_q),
        .b_neg (neg_rem_q),
        .a_c   (quo_c),
        .b_c   (rem_c)
    );

    assign d_shl_c = d_q << 1;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        k_d       = k_q;
        q_d       = q_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_pend_d = dz_pend_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d    = 1'b1;
                    k_d       = '0;
                    q_d       = '0;
                    d_d       = {1'b0, dvsor_mag_c};
                    neg_quo_d = bus.sgn & (bus.dvdnd[WIDTH-1] ^ bus.dvsor[WIDTH-1]);
                    neg_rem_d = bus.sgn & bus.dvdnd[WIDTH-1];
                    if (bus.dvsor == '0) begin
                        // Keep the raw dividend: it is returned as HI.
                        a_d       = bus.dvdnd;
                        dz_pend_d = 1'b1;
                        state_d   = FIX;
                    end else begin
                        a_d       = dvdnd_mag_c;
                        dz_pend_d = 1'b0;
                        state_d   = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (!d_q[WIDTH-1] && (d_shl_c <= {1'b0, a_q})) begin
                    d_d = d_shl_c;
                    k_d = k_q + CNT_W'(1);
                end else begin
                    state_d = SUB;
                end
            end
            SUB: begin
                if ({1'b0, a_q} >= d_q) begin
                    a_d = a_q - d_q[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                d_d = d_q >> 1;
                if (k_q == '0) begin
                    state_d = FIX;
                end else begin
                    k_d = k_q - CNT_W'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dz_pend_q) begin
                    lo_d = WIDTH'(DZ_QUOT);
                    hi_d = a_q;
                    dz_d = 1'b1;
                end else begin
                    lo_d = quo_c;
                    hi_d = rem_c;
                    dz_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge dvrst_n) begin
        if (!dvrst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            d_q       <= '0;
            k_q       <= '0;
            q_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            d_q       <= d_d;
            k_q       <= k_d;
            q_q       <= q_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_pend_q <= dz_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule : div_shiftsub

// File: tb/tb_div_shiftsub.sv
// Scoreboard bench for div_shiftsub: randomised and directed DIV/DIVU ops
// checked against a plain-arithmetic reference model, including latency.
module tb_div_shiftsub;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           lat;
        int           issue;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    div_shiftsub_if #(.WIDTH(W)) bus ();

    div_shiftsub dut (
        .clk     (clk),
        .dvrst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed/unsigned division by plain arithmetic; latency from
    // the largest power-of-two multiple of the divisor that fits the dividend.
    function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, ma, mb;
        int     k;
        e.issue = 0;
        if (b == '0) begin
            e.lo  = '1;
            e.hi  = a;
            e.dz  = 1'b1;
            e.lat = 1;
            return e;
        end
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            e.lo = W'(sa / sb);
            e.hi = W'(sa % sb);
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
        end else begin
            ma = longint'(a);
            mb = longint'(b);
            e.lo = a / b;
            e.hi = a % b;
        end
        e.dz = 1'b0;
        k = 0;
        while ((mb << (k + 1)) <= ma) k++;
        e.lat = 2 * k + 3;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(bus.done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lo", 64'(bus.lo), 64'(e.lo));
                chk("hi", 64'(bus.hi), 64'(e.hi));
                chk("dz", 64'(bus.dz), 64'(e.dz));
                chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                chk("busy_at_done", 64'(bus.busy), 64'(0));
            end
        end
    end

    // Issue one op once the divider is free; junk start pulses while busy.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (bus.busy === 1'b1 && t < 200) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.start = 1'b1;
                bus.sgn   = 1'($urandom);
                bus.dvdnd = $urandom;
                bus.dvsor = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("idle_timeout", 64'(bus.busy), 64'(0));
        e = model(s, a, b);
        e.issue = cyc + 1;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.sgn   = s;
        bus.dvdnd = a;
        bus.dvsor = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dvdnd = $urandom;
        bus.dvsor = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 64'(sb.size()), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        int done_seen;
        logic [W-1:0] a, b;
        n_cmp     = 0;
        n_err     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.dvdnd = '0;
        bus.dvsor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_dz",   64'(bus.dz),   64'(0));
        chk("rst_hi",   64'(bus.hi),   64'(0));
        chk("rst_lo",   64'(bus.lo),   64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back to back.
        issue(1'b0, 32'd100, 32'd7);
        issue(1'b1, -32'sd100, 32'd7);
        issue(1'b1, 32'd7, -32'sd100);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 32'd5, 32'd0);
        issue(1'b1, -32'sd9, 32'd0);
        issue(1'b0, 32'd3, 32'd7);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        issue(1'b1, -32'sd7, -32'sd2);
        drain();

        // Reset while the long op is in its subtract phase.
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        chk("midrst_hi",   64'(bus.hi),   64'(0));
        chk("midrst_lo",   64'(bus.lo),   64'(0));
        chk("midrst_dz",   64'(bus.dz),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'(0));

        // Random ops; divisor width varied so alignment depth spans 0..31.
        for (int i = 0; i < 1200; i++) begin
            a = $urandom >> $urandom_range(0, 8);
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            issue(1'($urandom), a, b);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_div_shiftsub
